peripheral_dbg_pu_or1k_spr_arbiter: RTL and testbench
=====================================================

Name: peripheral_dbg_pu_or1k_spr_arbiter

Overview:
Arbiter for the OR1K SPR bus in the cpu_clk_i domain. It shares one SPR master port between NUM_REQ requesters. Requester 0 is the debug bridge's CPU-side port; the others are, for example, a trace unit or a second debug bridge. Arbitration is round-robin. Single-cycle and multi-cycle SPR acks are both supported, and there is an optional no-ack timeout.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT, 255, cycles without spr_ack_i before forced termination (timeout build only, 1..65535)

Ports:
cpu_clk_i  in  1  SPR bus clock
rst_i  in  1  reset; asynchronous, active-high
req_stb_i  in  NUM_REQ  per-requester access strobe, level, held until ack
req_we_i  in  NUM_REQ  per-requester write (1) / read (0)
req_addr_i  in  32*NUM_REQ  per-requester SPR address; requester k uses bits [32k+31:32k]
req_data_i  in  32*NUM_REQ  per-requester write data, same packing
req_data_o  out  32  read data, broadcast to all requesters, valid when that requester's ack is high
req_ack_o  out  NUM_REQ  one-hot completion pulse to the granted requester
req_err_o  out  NUM_REQ  timeout completion flag, coincident with req_ack_o
grant_o  out  NUM_REQ  registered one-hot grant; all-zero when idle
busy_o  out  1  high while in XFER
spr_addr_o  out  32  muxed address of the granted requester
spr_data_o  out  32  muxed write data
spr_we_o  out  1  muxed write enable
spr_stb_o  out  1  SPR strobe
spr_data_i  in  32  SPR read data
spr_ack_i  in  1  SPR ack; may be high in the first strobe cycle (single-cycle access)

Behaviour:
- Reset values: state IDLE, grant_o=0, last-grant pointer = NUM_REQ-1 (so requester 0 wins first), spr_stb_o=0, req_ack_o=0, req_err_o=0, busy_o=0, timeout counter 0.
- Muxed outputs: spr_addr_o, spr_data_o and spr_we_o select the granted requester; when grant_o=0 they are 0.
- req_data_o = spr_data_i, combinational passthrough.
- FSM states: IDLE, XFER, GAP.
- IDLE:
  - If any req_stb_i is high, choose the first requester with stb high, scanning from last_grant+1 upward with modulo wrap.
  - Register the choice in grant_o and last_grant; go to XFER.
  - No spr_stb_o in IDLE. Grant latency is 1 cycle from stb.
- XFER:
  - spr_stb_o = req_stb_i[g], where g is the granted requester.
  - If spr_ack_i && req_stb_i[g]: req_ack_o[g]=1 in the same cycle (combinational). Next state GAP; grant_o cleared at that edge.
  - If req_stb_i[g] drops before ack (abort): spr_stb_o drops in that cycle. Next state GAP; no ack is issued.
  - An ack arriving while spr_stb_o=0 is ignored.
- GAP: one mandatory idle cycle, so a requester can drop stb after its ack; then IDLE. Any stb seen in GAP is arbitrated in the following IDLE cycle.
- Back-to-back throughput: one access per 3 cycles minimum (IDLE, XFER, GAP) for single-cycle acks.
- Fairness:
  - Pointer updates only on grant.
  - With all requesters continuously requesting, grants cycle 0,1,...,NUM_REQ-1,0.
  - A requester that has its stb held waits at most NUM_REQ-1 other accesses.
- Simultaneous events:
  - New requests during XFER are not visible until IDLE.
  - Only one requester's stb is muxed onto the bus.
  - Reads and writes are treated identically; the requester latches req_data_o on its ack.
- Reset mid-transfer: spr_stb_o and all acks drop asynchronously. The interrupted access is not completed.
- grant_o, busy_o and the state are registered outputs. req_ack_o and spr_stb_o are combinational from state, grant, stb and ack.

Optional Feature:
Macro SPR_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to XFER and increments each XFER cycle without spr_ack_i.
  - When the counter equals TIMEOUT-1 and there is still no ack: req_ack_o[g]=1 and req_err_o[g]=1 in that cycle; spr_stb_o is driven 0 in that cycle; next state GAP.
  - If a real ack coincides with that cycle, the real ack wins and req_err_o stays 0.
- Not defined: req_err_o is tied to 0, no counter exists, and XFER waits indefinitely for ack or abort.

Test Plan:
1. Reset; req_stb_i=2'b01, we=1, addr=0x0000_3010, data=0x1234_5678; spr_ack_i high in the first strobe cycle -> grant_o=01 one cycle after stb; spr_stb_o, spr_addr_o=0x3010, spr_data_o=0x12345678, spr_we_o=1 and req_ack_o=01 all in the same cycle; GAP follows; busy_o low 2 cycles after stb.
2. Both stbs raised together after reset and held -> grant order 0,1,0,1; each ack goes only to its granted requester; 3 cycles per access.
3. Requester 1 read, addr 0x2800; spr_ack_i delayed 3 cycles with spr_data_i=0xCAFE_F00D -> spr_stb_o high for 4 cycles; req_ack_o=10 on the 4th; req_data_o=0xCAFEF00D in that cycle.
4. Requester 0 drops stb after 2 XFER cycles with no ack -> spr_stb_o falls the same cycle; no req_ack_o; next IDLE services pending requester 1.
5. SPR_ARB_TIMEOUT_EN, TIMEOUT=8, ack never asserted -> req_ack_o and req_err_o pulse on the 8th XFER cycle; then GAP, IDLE. Repeat with ack on the 8th cycle -> req_err_o=0.
6. rst_i asserted in the 2nd cycle of a multi-cycle XFER -> spr_stb_o, grant_o and busy_o go 0 immediately; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/peripheral_dbg_pu_or1k_spr_arbiter.sv
// rtl/peripheral_dbg_pu_or1k_spr_arbiter.sv - round-robin arbiter sharing one OR1K SPR master port
//
// Purpose: shares a single SPR bus master between NUM_REQ requesters
// (requester 0 is the debug bridge CPU-side port). Round-robin arbitration,
// IDLE -> XFER -> GAP per access, single- and multi-cycle acks.
//
// Optional build macro: SPR_ARB_TIMEOUT_EN. When defined, an access with no
// spr_ack_i for TIMEOUT XFER cycles is terminated with req_ack_o + req_err_o.
// When undefined, req_err_o is 0 and XFER waits for ack or abort.
//
// Ports:
//   cpu_clk_i, rst_i            clock; asynchronous active-high reset
//   req_stb_i/we_i/addr_i/data_i requester side, addr/data packed 32 bits per requester
//   req_data_o                  read data broadcast (passthrough of spr_data_i)
//   req_ack_o, req_err_o        one-hot completion / timeout flag to granted requester
//   grant_o, busy_o             registered grant (one-hot, 0 when idle), XFER indicator
//   spr_addr_o/data_o/we_o/stb_o SPR master side outputs
//   spr_data_i, spr_ack_i       SPR master side inputs

module peripheral_dbg_pu_or1k_spr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                   cpu_clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_stb_i,
    input  logic [NUM_REQ-1:0]     req_we_i,
    input  logic [32*NUM_REQ-1:0]  req_addr_i,
    input  logic [32*NUM_REQ-1:0]  req_data_i,
    output logic [31:0]            req_data_o,
    output logic [NUM_REQ-1:0]     req_ack_o,
    output logic [NUM_REQ-1:0]     req_err_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   busy_o,
    output logic [31:0]            spr_addr_o,
    output logic [31:0]            spr_data_o,
    output logic                   spr_we_o,
    output logic                   spr_stb_o,
    input  logic [31:0]            spr_data_i,
    input  logic                   spr_ack_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("peripheral_dbg_pu_or1k_spr_arbiter: NUM_REQ or TIMEOUT out of range");
    end

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] last_grant_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             in_xfer;
    logic             gnt_stb;
    logic             real_ack;
    logic             tmo_fire;
    logic             done;

    // Scan starts one past the last grant and wraps, so a held request waits
    // for at most NUM_REQ-1 other accesses.
    always_comb begin
        int c;
        c          = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            c = (int'(last_grant_q) + i) % NUM_REQ;
            if (!pick_valid && req_stb_i[c]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(c);
            end
        end
    end

    assign in_xfer  = (state_q == ST_XFER);
    assign gnt_stb  = in_xfer && req_stb_i[grant_idx_q];
    assign real_ack = gnt_stb && spr_ack_i;

`ifdef SPR_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Counter sits at zero outside XFER, so it is zero on XFER entry.
    always_ff @(posedge cpu_clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else if (!in_xfer) begin
            tmo_cnt_q <= '0;
        end else if (!spr_ack_i) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    // A real ack in the last cycle wins over the timeout.
    assign tmo_fire  = gnt_stb && !spr_ack_i && (tmo_cnt_q == 16'(TIMEOUT - 1));
    assign req_err_o = grant_o & {NUM_REQ{tmo_fire}};
`else
    assign tmo_fire  = 1'b0;
    assign req_err_o = '0;
`endif

    assign done       = real_ack || tmo_fire;
    assign spr_stb_o  = gnt_stb && !tmo_fire;
    assign req_ack_o  = grant_o & {NUM_REQ{done}};
    assign req_data_o = spr_data_i;

    assign spr_addr_o = (|grant_o) ? req_addr_i[32*grant_idx_q +: 32] : 32'd0;
    assign spr_data_o = (|grant_o) ? req_data_i[32*grant_idx_q +: 32] : 32'd0;
    assign spr_we_o   = (|grant_o) && req_we_i[grant_idx_q];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_valid) state_d = ST_XFER;
            // Dropped strobe (abort), ack or timeout all end the access.
            ST_XFER: if (!gnt_stb || done) state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            busy_o       <= 1'b0;
            grant_o      <= '0;
            grant_idx_q  <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d == ST_XFER);
            if (state_q == ST_IDLE && pick_valid) begin
                grant_o      <= NUM_REQ'(1) << pick_idx;
                grant_idx_q  <= pick_idx;
                last_grant_q <= pick_idx;
            end else if (state_d != ST_XFER) begin
                grant_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_peripheral_dbg_pu_or1k_spr_arbiter.sv
// tb/tb_peripheral_dbg_pu_or1k_spr_arbiter.sv - self-checking bench for the SPR arbiter
module tb_peripheral_dbg_pu_or1k_spr_arbiter;

    localparam int NREQ = 3;
    localparam int TMO  = 8;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [NREQ-1:0]      req_stb_i, req_we_i;
    logic [32*NREQ-1:0]   req_addr_i, req_data_i;
    logic [31:0]          req_data_o;
    logic [NREQ-1:0]      req_ack_o, req_err_o, grant_o;
    logic                 busy_o;
    logic [31:0]          spr_addr_o, spr_data_o, spr_data_i;
    logic                 spr_we_o, spr_stb_o, spr_ack_i;

    int checks = 0;
    int errors = 0;

    peripheral_dbg_pu_or1k_spr_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
        .cpu_clk_i (clk),
        .rst_i     (rst_i),
        .req_stb_i (req_stb_i),
        .req_we_i  (req_we_i),
        .req_addr_i(req_addr_i),
        .req_data_i(req_data_i),
        .req_data_o(req_data_o),
        .req_ack_o (req_ack_o),
        .req_err_o (req_err_o),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .spr_addr_o(spr_addr_o),
        .spr_data_o(spr_data_o),
        .spr_we_o  (spr_we_o),
        .spr_stb_o (spr_stb_o),
        .spr_data_i(spr_data_i),
        .spr_ack_i (spr_ack_i)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_stb_i = '0; req_we_i = '0; req_addr_i = '0; req_data_i = '0;
        spr_data_i = '0; spr_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        clear_inputs();
        req_stb_i = 3'b011;
        @(negedge clk);
        checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (spr_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", spr_stb_o); end
        checks++; if (req_ack_o !== 3'b000 || req_err_o !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b/%b expected 000/000", req_ack_o, req_err_o); end
        checks++; if (spr_addr_o !== 32'd0 || spr_we_o !== 1'b0) begin errors++; $display("FAIL reset_mux: got %h/%b expected 0/0", spr_addr_o, spr_we_o); end
        do_reset();
    endtask

    task automatic test_single();
        req_stb_i = 3'b001; req_we_i = 3'b001;
        req_addr_i[31:0] = 32'h0000_3010; req_data_i[31:0] = 32'h1234_5678;
        @(negedge clk);
        checks++; if (grant_o !== 3'b000 || spr_stb_o !== 1'b0) begin errors++; $display("FAIL single_idle: got grant %b stb %b expected 000 0", grant_o, spr_stb_o); end
        next_cycle();
        spr_ack_i = 1'b1;
        @(negedge clk);
        checks++; if (grant_o !== 3'b001 || busy_o !== 1'b1) begin errors++; $display("FAIL single_grant: got %b busy %b expected 001 1", grant_o, busy_o); end
        checks++; if (spr_stb_o !== 1'b1 || spr_we_o !== 1'b1) begin errors++; $display("FAIL single_stb_we: got %b %b expected 1 1", spr_stb_o, spr_we_o); end
        checks++; if (spr_addr_o !== 32'h3010 || spr_data_o !== 32'h1234_5678) begin errors++; $display("FAIL single_mux: got %h %h expected 00003010 12345678", spr_addr_o, spr_data_o); end
        checks++; if (req_ack_o !== 3'b001) begin errors++; $display("FAIL single_ack: got %b expected 001", req_ack_o); end
        next_cycle();
        req_stb_i = '0; spr_ack_i = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || grant_o !== 3'b000 || req_ack_o !== 3'b000) begin errors++; $display("FAIL single_gap: got busy %b grant %b ack %b expected 0 000 000", busy_o, grant_o, req_ack_o); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g;
        do_reset();
        req_stb_i = 3'b011;
        for (int k = 0; k < 4; k++) begin
            exp_g = NREQ'(1) << (k % 2);
            @(negedge clk);
            checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL rr_idle%0d: got %b expected 000", k, grant_o); end
            next_cycle();
            spr_ack_i = 1'b1;
            @(negedge clk);
            checks++; if (grant_o !== exp_g || req_ack_o !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got grant %b ack %b expected %b", k, grant_o, req_ack_o, exp_g); end
            next_cycle();
            spr_ack_i = 1'b0;
            @(negedge clk);
            checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: got busy %b expected 0", k, busy_o); end
            next_cycle();
        end
        req_stb_i = '0;
    endtask

    task automatic test_delayed_read();
        req_stb_i = 3'b010; req_we_i = 3'b000;
        req_addr_i[63:32] = 32'h0000_2800;
        next_cycle();
        for (int j = 0; j < 4; j++) begin
            spr_ack_i  = (j == 3);
            spr_data_i = (j == 3) ? 32'hCAFE_F00D : 32'h0;
            @(negedge clk);
            checks++; if (spr_stb_o !== 1'b1 || spr_addr_o !== 32'h2800 || spr_we_o !== 1'b0) begin errors++; $display("FAIL delay_bus%0d: got stb %b addr %h we %b expected 1 00002800 0", j, spr_stb_o, spr_addr_o, spr_we_o); end
            checks++; if (req_ack_o !== ((j == 3) ? 3'b010 : 3'b000)) begin errors++; $display("FAIL delay_ack%0d: got %b", j, req_ack_o); end
            if (j == 3) begin
                checks++; if (req_data_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL delay_rdata: got %h expected cafef00d", req_data_o); end
            end
            next_cycle();
        end
        req_stb_i = '0; spr_ack_i = 1'b0;
        next_cycle();
    endtask

    task automatic test_abort();
        req_stb_i = 3'b011;
        next_cycle();
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            checks++; if (grant_o !== 3'b001 || spr_stb_o !== 1'b1) begin errors++; $display("FAIL abort_xfer%0d: got grant %b stb %b expected 001 1", j, grant_o, spr_stb_o); end
            next_cycle();
        end
        req_stb_i = 3'b010; spr_ack_i = 1'b1;
        @(negedge clk);
        checks++; if (spr_stb_o !== 1'b0 || req_ack_o !== 3'b000) begin errors++; $display("FAIL abort_drop: got stb %b ack %b expected 0 000", spr_stb_o, req_ack_o); end
        next_cycle();
        spr_ack_i = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || grant_o !== 3'b000) begin errors++; $display("FAIL abort_gap: got busy %b grant %b expected 0 000", busy_o, grant_o); end
        next_cycle();
        next_cycle();
        spr_ack_i = 1'b1;
        @(negedge clk);
        checks++; if (grant_o !== 3'b010 || req_ack_o !== 3'b010) begin errors++; $display("FAIL abort_next: got grant %b ack %b expected 010 010", grant_o, req_ack_o); end
        next_cycle();
        req_stb_i = '0; spr_ack_i = 1'b0;
        next_cycle();
    endtask

`ifdef SPR_ARB_TIMEOUT_EN
    task automatic test_timeout();
        for (int r = 0; r < 2; r++) begin
            req_stb_i = 3'b001;
            next_cycle();
            for (int j = 1; j <= TMO; j++) begin
                spr_ack_i = (r == 1) && (j == TMO);
                @(negedge clk);
                if (j < TMO) begin
                    checks++; if (req_ack_o !== 3'b000 || req_err_o !== 3'b000 || spr_stb_o !== 1'b1) begin errors++; $display("FAIL tmo_wait%0d_%0d: got ack %b err %b stb %b", r, j, req_ack_o, req_err_o, spr_stb_o); end
                end else begin
                    checks++; if (req_ack_o !== 3'b001) begin errors++; $display("FAIL tmo_ack%0d: got %b expected 001", r, req_ack_o); end
                    checks++; if (req_err_o !== ((r == 0) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL tmo_err%0d: got %b", r, req_err_o); end
                    checks++; if (spr_stb_o !== (r == 1)) begin errors++; $display("FAIL tmo_stb%0d: got %b", r, spr_stb_o); end
                end
                next_cycle();
            end
            req_stb_i = '0; spr_ack_i = 1'b0;
            @(negedge clk);
            checks++; if (busy_o !== 1'b0 || req_ack_o !== 3'b000) begin errors++; $display("FAIL tmo_gap%0d: got busy %b ack %b", r, busy_o, req_ack_o); end
            next_cycle();
        end
    endtask
`else
    task automatic test_no_timeout();
        req_stb_i = 3'b001;
        next_cycle();
        for (int j = 1; j <= 2 * TMO; j++) begin
            @(negedge clk);
            checks++; if (req_ack_o !== 3'b000 || req_err_o !== 3'b000 || spr_stb_o !== 1'b1) begin errors++; $display("FAIL notmo_wait%0d: got ack %b err %b stb %b", j, req_ack_o, req_err_o, spr_stb_o); end
            next_cycle();
        end
        spr_ack_i = 1'b1;
        @(negedge clk);
        checks++; if (req_ack_o !== 3'b001 || req_err_o !== 3'b000) begin errors++; $display("FAIL notmo_ack: got ack %b err %b expected 001 000", req_ack_o, req_err_o); end
        next_cycle();
        req_stb_i = '0; spr_ack_i = 1'b0;
        next_cycle();
    endtask
`endif

    task automatic test_reset_mid();
        req_stb_i = 3'b010;
        next_cycle();
        next_cycle();
        rst_i = 1'b1;
        #1;
        checks++; if (spr_stb_o !== 1'b0 || grant_o !== 3'b000 || busy_o !== 1'b0 || req_ack_o !== 3'b000) begin errors++; $display("FAIL rstmid: got stb %b grant %b busy %b ack %b expected all 0", spr_stb_o, grant_o, busy_o, req_ack_o); end
        next_cycle();
        req_stb_i = 3'b011;
        rst_i = 1'b0;
        next_cycle();
        spr_ack_i = 1'b1;
        @(negedge clk);
        checks++; if (grant_o !== 3'b001 || req_ack_o !== 3'b001) begin errors++; $display("FAIL rstmid_first: got grant %b ack %b expected 001 001", grant_o, req_ack_o); end
        next_cycle();
        req_stb_i = '0; spr_ack_i = 1'b0;
        next_cycle();
    endtask

    task automatic test_random();
        int ptr, w, d;
        logic [NREQ-1:0] mask, exp_g;
        logic [31:0] addr_a [NREQ];
        logic [31:0] data_a [NREQ];
        logic [NREQ-1:0] we_a;
        logic [31:0] rd;
        do_reset();
        ptr = NREQ - 1;
        for (int n = 0; n < 60; n++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            we_a = NREQ'($urandom);
            for (int k = 0; k < NREQ; k++) begin
                addr_a[k] = $urandom;
                data_a[k] = $urandom;
                req_addr_i[32*k +: 32] = addr_a[k];
                req_data_i[32*k +: 32] = data_a[k];
            end
            w = -1;
            for (int i = 1; i <= NREQ; i++) begin
                if (w < 0 && mask[(ptr + i) % NREQ]) w = (ptr + i) % NREQ;
            end
            exp_g = NREQ'(1) << w;
            req_stb_i = mask; req_we_i = we_a; spr_ack_i = 1'b0;
            @(negedge clk);
            checks++; if (grant_o !== '0 || spr_stb_o !== 1'b0) begin errors++; $display("FAIL rnd_idle%0d: got grant %b stb %b", n, grant_o, spr_stb_o); end
            next_cycle();
            d = $urandom_range(0, 3);
            for (int j = 0; j <= d; j++) begin
                rd = $urandom;
                spr_ack_i = (j == d); spr_data_i = rd;
                @(negedge clk);
                checks++; if (grant_o !== exp_g || spr_stb_o !== 1'b1) begin errors++; $display("FAIL rnd_grant%0d: got %b stb %b expected %b 1", n, grant_o, spr_stb_o, exp_g); end
                checks++; if (spr_addr_o !== addr_a[w] || spr_data_o !== data_a[w] || spr_we_o !== we_a[w]) begin errors++; $display("FAIL rnd_mux%0d: got %h %h %b expected %h %h %b", n, spr_addr_o, spr_data_o, spr_we_o, addr_a[w], data_a[w], we_a[w]); end
                checks++; if (req_ack_o !== ((j == d) ? exp_g : '0) || req_err_o !== '0) begin errors++; $display("FAIL rnd_ack%0d: got ack %b err %b", n, req_ack_o, req_err_o); end
                if (j == d) begin
                    checks++; if (req_data_o !== rd) begin errors++; $display("FAIL rnd_rdata%0d: got %h expected %h", n, req_data_o, rd); end
                end
                next_cycle();
            end
            ptr = w;
            req_stb_i = '0; spr_ack_i = 1'b0;
            @(negedge clk);
            checks++; if (busy_o !== 1'b0 || grant_o !== '0) begin errors++; $display("FAIL rnd_gap%0d: got busy %b grant %b", n, busy_o, grant_o); end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_delayed_read();
        test_abort();
`ifdef SPR_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
